fetch_queue: RTL and testbench

//   Decoupled instruction prefetch unit. Owns the fetch PC and drives the combinational inst_memory.

---
 rtl/fetch_queue.sv | 98 +++++++++
 tb/tb_fetch_queue.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Decoupled instruction prefetch queue between the instruction memory and ID.
// Owns the fetch PC, buffers up to DEPTH {pc, inst} pairs in a circular FIFO
// and presents the oldest entry to ID combinationally.
module fetch_queue #(
    parameter int unsigned          INST_W   = 32,
    parameter int unsigned          ADDR_W   = 32,
    parameter int unsigned          DEPTH    = 4,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [ADDR_W-1:0]             flush_pc,
    input  logic                          id_stall,
    input  logic [INST_W-1:0]             imem_inst,
    output logic [ADDR_W-1:0]             imem_addr,
    output logic                          imem_rd_en,
    output logic                          id_valid,
    output logic [INST_W-1:0]             id_inst,
    output logic [ADDR_W-1:0]             id_pc,
    output logic [$clog2(DEPTH+1)-1:0]    count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);
    localparam logic [INST_W-1:0] NOP_INST = INST_W'(32'h0000_0013);

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [ADDR_W-1:0] fetch_pc;
    logic              push;
    logic              pop;
    logic              full;

    // Redirect targets are word aligned; the low two bits are deliberately ignored.
    logic unused_flush_lo;
    assign unused_flush_lo = ^flush_pc[1:0];

    // Queue handshake: flush and reset suppress both sides; full blocks fetch even on a pop.
    always_comb begin
        full       = (count == CNT_W'(DEPTH));
        push       = !rst && !flush && !full;
        pop        = id_valid && !id_stall && !flush;
        imem_rd_en = push;
        imem_addr  = rst ? '0 : fetch_pc;
    end

    // Oldest entry to ID, NOP bubble when empty.
    always_comb begin
        id_valid = !rst && (count != '0);
        id_inst  = NOP_INST;
        id_pc    = '0;
        if (id_valid) begin
            id_inst = inst_mem[rd_ptr];
            id_pc   = pc_mem[rd_ptr];
        end
    end

    // Entry storage; contents are don't-care until counted as occupied.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= imem_addr;
            inst_mem[wr_ptr] <= imem_inst;
        end
    end

    // Pointers, occupancy and fetch PC; flush redirects and empties the queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            fetch_pc <= RESET_PC;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            fetch_pc <= {flush_pc[ADDR_W-1:2], 2'b00};
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + PTR_W'(1);
                fetch_pc <= fetch_pc + ADDR_W'(4);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (!push && pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table, async reset
// sequence, randomized run against a queue-based reference model, and PC wrap.
module tb_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, flush, id_stall;
    logic [31:0] flush_pc, imem_inst, imem_addr, id_inst, id_pc, salt;
    logic        imem_rd_en, id_valid;
    logic [2:0]  count;

    logic        rst_w;
    logic [31:0] imem_inst_w, imem_addr_w, id_inst_w, id_pc_w;
    logic        imem_rd_en_w, id_valid_w;
    logic [2:0]  count_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Instruction memory: a word derived from its address.
    assign imem_inst   = imem_addr ^ salt;
    assign imem_inst_w = imem_addr_w;

    fetch_queue #(.INST_W(32), .ADDR_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .flush(flush), .flush_pc(flush_pc), .id_stall(id_stall),
        .imem_inst(imem_inst), .imem_addr(imem_addr), .imem_rd_en(imem_rd_en),
        .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc), .count(count)
    );

    fetch_queue #(.INST_W(32), .ADDR_W(32), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk(clk), .rst(rst_w), .flush(1'b0), .flush_pc(32'h0), .id_stall(1'b0),
        .imem_inst(imem_inst_w), .imem_addr(imem_addr_w), .imem_rd_en(imem_rd_en_w),
        .id_valid(id_valid_w), .id_inst(id_inst_w), .id_pc(id_pc_w), .count(count_w)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of {pc, inst} and a fetch pointer.
    typedef struct { logic [31:0] pc; logic [31:0] inst; } entry_t;
    entry_t      q[$];
    logic [31:0] mpc = 32'h0;

    task automatic model_edge(input bit fl, input logic [31:0] fpc, input bit st);
        bit do_push, do_pop;
        entry_t e;
        if (fl) begin
            q.delete();
            mpc = fpc & 32'hFFFF_FFFC;
        end else begin
            do_push = (q.size() < DEPTH);
            do_pop  = (q.size() != 0) && !st;
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                e.pc = mpc;
                e.inst = mpc ^ salt;
                q.push_back(e);
                mpc = mpc + 32'd4;
            end
        end
    endtask

    task automatic model_check();
        bit v;
        v = (q.size() != 0);
        chk("m_count", 32'(count), 32'(q.size()));
        chk("m_valid", 32'(id_valid), 32'(v));
        chk("m_pc",    id_pc,   v ? q[0].pc   : 32'h0);
        chk("m_inst",  id_inst, v ? q[0].inst : 32'h13);
        chk("m_rd_en", 32'(imem_rd_en), 32'(!flush && q.size() < DEPTH));
        chk("m_addr",  imem_addr, mpc);
    endtask

    typedef struct {
        bit fl; logic [31:0] fpc; bit st;
        int cnt; bit vld; logic [31:0] pc; logic [31:0] inst; bit rd; logic [31:0] addr;
    } vec_t;
    vec_t tbl[17];

    initial begin
        //            fl  fpc           st  cnt vld pc            inst          rd  addr
        tbl[0]  = '{0, 32'h0,   0, 0, 0, 32'h0,   32'h13,  1, 32'h0};
        tbl[1]  = '{0, 32'h0,   0, 1, 1, 32'h0,   32'h0,   1, 32'h4};
        tbl[2]  = '{0, 32'h0,   0, 1, 1, 32'h4,   32'h4,   1, 32'h8};
        tbl[3]  = '{0, 32'h0,   0, 1, 1, 32'h8,   32'h8,   1, 32'hC};
        tbl[4]  = '{0, 32'h0,   0, 1, 1, 32'hC,   32'hC,   1, 32'h10};
        tbl[5]  = '{0, 32'h0,   1, 1, 1, 32'h10,  32'h10,  1, 32'h14};
        tbl[6]  = '{0, 32'h0,   1, 2, 1, 32'h10,  32'h10,  1, 32'h18};
        tbl[7]  = '{0, 32'h0,   1, 3, 1, 32'h10,  32'h10,  1, 32'h1C};
        tbl[8]  = '{0, 32'h0,   1, 4, 1, 32'h10,  32'h10,  0, 32'h20};
        tbl[9]  = '{0, 32'h0,   1, 4, 1, 32'h10,  32'h10,  0, 32'h20};
        tbl[10] = '{1, 32'h103, 1, 4, 1, 32'h10,  32'h10,  0, 32'h20};
        tbl[11] = '{0, 32'h0,   1, 0, 0, 32'h0,   32'h13,  1, 32'h100};
        tbl[12] = '{0, 32'h0,   1, 1, 1, 32'h100, 32'h100, 1, 32'h104};
        tbl[13] = '{0, 32'h0,   1, 2, 1, 32'h100, 32'h100, 1, 32'h108};
        tbl[14] = '{1, 32'h203, 0, 3, 1, 32'h100, 32'h100, 0, 32'h10C};
        tbl[15] = '{0, 32'h0,   0, 0, 0, 32'h0,   32'h13,  1, 32'h200};
        tbl[16] = '{0, 32'h0,   0, 1, 1, 32'h200, 32'h200, 1, 32'h204};

        rst = 1'b1; rst_w = 1'b1; flush = 1'b0; flush_pc = '0; id_stall = 1'b0; salt = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_valid", 32'(id_valid), 0);
        chk("rst_inst",  id_inst, 32'h13);
        chk("rst_pc",    id_pc, 0);
        chk("rst_rd_en", 32'(imem_rd_en), 0);
        chk("rst_addr",  imem_addr, 0);
        rst = 1'b0;

        // Directed table: streaming, stall fill to full, flush while full+stalled, flush at count 3.
        for (int i = 0; i < 17; i++) begin
            flush = tbl[i].fl; flush_pc = tbl[i].fpc; id_stall = tbl[i].st;
            @(negedge clk);
            chk($sformatf("t%0d_count", i), 32'(count), 32'(tbl[i].cnt));
            chk($sformatf("t%0d_valid", i), 32'(id_valid), 32'(tbl[i].vld));
            chk($sformatf("t%0d_pc", i),    id_pc, tbl[i].pc);
            chk($sformatf("t%0d_inst", i),  id_inst, tbl[i].inst);
            chk($sformatf("t%0d_rd_en", i), 32'(imem_rd_en), 32'(tbl[i].rd));
            chk($sformatf("t%0d_addr", i),  imem_addr, tbl[i].addr);
            @(posedge clk);
            model_edge(flush, flush_pc, id_stall);
            #1;
        end
        flush = 1'b0;

        // Async reset between edges with two entries queued.
        id_stall = 1'b1;
        @(posedge clk);
        model_edge(1'b0, 32'h0, 1'b1);
        #1;
        chk("pre_rst_count", 32'(count), 2);
        #2 rst = 1'b1;
        #1;
        chk("arst_count", 32'(count), 0);
        chk("arst_valid", 32'(id_valid), 0);
        chk("arst_rd_en", 32'(imem_rd_en), 0);
        chk("arst_addr",  imem_addr, 0);
        q.delete();
        mpc = 32'h0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        model_check();
        @(posedge clk);
        model_edge(1'b0, 32'h0, 1'b1);
        #1;
        @(negedge clk);
        chk("post_rst_pc", id_pc, 32'h0);
        model_check();
        @(posedge clk);
        model_edge(1'b0, 32'h0, 1'b1);
        #1;

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            flush    = ($urandom_range(0, 9) == 0);
            flush_pc = $urandom;
            id_stall = $urandom_range(0, 1) == 1;
            salt     = $urandom;
            @(negedge clk);
            model_check();
            @(posedge clk);
            model_edge(flush, flush_pc, id_stall);
            #1;
        end
        flush = 1'b0;

        // Fetch PC wrap-around on the second instance.
        rst_w = 1'b0;
        @(negedge clk);
        chk("w0_valid", 32'(id_valid_w), 0);
        chk("w0_addr", imem_addr_w, 32'hFFFF_FFF8);
        @(negedge clk);
        chk("w1_pc", id_pc_w, 32'hFFFF_FFF8);
        @(negedge clk);
        chk("w2_pc", id_pc_w, 32'hFFFF_FFFC);
        chk("w2_addr", imem_addr_w, 32'h0);
        @(negedge clk);
        chk("w3_pc", id_pc_w, 32'h0);
        chk("w3_inst", id_inst_w, 32'h0);
        @(negedge clk);
        chk("w4_pc", id_pc_w, 32'h4);
        chk("w4_count", 32'(count_w), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
